// File: rtl/veggie_pkg.sv
// Shared constants and enums for the frame-buffer painter.
package veggie_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FB_ADDR_W = 19;

    typedef enum logic {
        OP_RECT  = 1'b0,
        OP_CLEAR = 1'b1
    } paint_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL,
        ST_DONE
    } paint_state_t;

endpackage

// File: rtl/frame_painter_if.sv
// Command bus and frame-buffer write port of the painter.
// master = command source / buffer side, slave = painter.
interface frame_painter_if #(
    parameter int ADDR_W = veggie_pkg::FB_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [9:0]        cmd_w;
    logic [9:0]        cmd_h;
    logic [7:0]        cmd_colour;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        input  cmd_ready, busy, done, wr_addr, wr_data, wr_en
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        output cmd_ready, busy, done, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/frame_painter.sv
// Rectangle-fill / full-screen-clear writer: clips one command to the
// screen and emits one pixel write per clock. All outputs are registered
// from the next-state values, so wr_* move together.
module frame_painter
    import veggie_pkg::*;
#(
    parameter int H_RES  = veggie_pkg::H_RES,
    parameter int V_RES  = veggie_pkg::V_RES,
    parameter int ADDR_W = veggie_pkg::FB_ADDR_W
) (
    input  logic          Clk,
    input  logic          reset_n,
    frame_painter_if.slave bus
);

    localparam logic [10:0] HRES11 = 11'(H_RES);
    localparam logic [10:0] VRES11 = 11'(V_RES);

    // Row base y*H_RES as a constant shift-add; for 640 this is (y<<9)+(y<<7).
    function automatic logic [ADDR_W-1:0] times_hres(input logic [9:0] v);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < ADDR_W; b++)
            if (H_RES[b]) acc = acc + (ADDR_W'(v) << b);
        return acc;
    endfunction

    paint_state_t      state_q, state_d;
    logic [9:0]        x_q, y_q, w_q, h_q;
    logic [7:0]        colour_q;
    logic [10:0]       wc_q, wc_d, hc_q, hc_d, col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic              accept, clipped, last_col, last_row;
    logic [10:0]       w_room, h_room;

    // 11-bit arithmetic so x+w and H_RES-x never wrap.
    assign accept   = bus.cmd_valid && cmd_ready_q;
    assign clipped  = ({1'b0, x_q} >= HRES11) || ({1'b0, y_q} >= VRES11) ||
                      (w_q == 10'd0) || (h_q == 10'd0);
    assign w_room   = HRES11 - {1'b0, x_q};
    assign h_room   = VRES11 - {1'b0, y_q};
    assign last_col = (col_q == wc_q - 11'd1);
    assign last_row = (row_q == hc_q - 11'd1);

    // State register.
    always_ff @(posedge Clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: state_d = clipped ? ST_DONE : ST_FILL;
            ST_FILL:  if (last_col && last_row) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter / clip datapath: SETUP computes the clipped size and row base,
    // FILL walks columns then rows.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        wc_d       = wc_q;
        hc_d       = hc_q;
        case (state_q)
            ST_SETUP: begin
                col_d      = '0;
                row_d      = '0;
                row_base_d = times_hres(y_q);
                wc_d       = ({1'b0, w_q} < w_room) ? {1'b0, w_q} : w_room;
                hc_d       = ({1'b0, h_q} < h_room) ? {1'b0, h_q} : h_room;
            end
            ST_FILL: begin
                if (last_col) begin
                    col_d      = '0;
                    row_d      = row_q + 11'd1;
                    row_base_d = row_base_q + ADDR_W'(H_RES);
                end else begin
                    col_d = col_q + 11'd1;
                end
            end
            default: ;
        endcase
    end

    // Output logic, evaluated on next-state values so the registers line up
    // with the state they describe. Address/data hold while not writing.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        wr_en_d     = (state_d == ST_FILL);
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = row_base_d + ADDR_W'(x_q) + ADDR_W'(col_d);
            wr_data_d = colour_q;
        end
    end

    // Command latch, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            colour_q    <= '0;
            wc_q        <= '0;
            hc_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if (accept) begin
                colour_q <= bus.cmd_colour;
                if (paint_op_t'(bus.cmd_op) == OP_CLEAR) begin
                    x_q <= '0;
                    y_q <= '0;
                    w_q <= 10'(H_RES);
                    h_q <= 10'(V_RES);
                end else begin
                    x_q <= bus.cmd_x;
                    y_q <= bus.cmd_y;
                    w_q <= bus.cmd_w;
                    h_q <= bus.cmd_h;
                end
            end
            wc_q        <= wc_d;
            hc_q        <= hc_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_frame_painter.sv
// Bench for frame_painter: a full-size instance for the directed rectangle
// cases and a 32x24 instance so a complete CLEAR stays short. A cycle-keyed
// model predicts every write, done, busy and ready value per cycle.
module tb_frame_painter;

    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clk = ~Clk;

    frame_painter_if #(.ADDR_W(19)) bus ();
    frame_painter_if #(.ADDR_W(10)) sbus ();

    frame_painter #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
        .Clk(Clk), .reset_n(reset_n), .bus(bus)
    );
    frame_painter #(.H_RES(32), .V_RES(24), .ADDR_W(10)) sdut (
        .Clk(Clk), .reset_n(reset_n), .bus(sbus)
    );

    // cyc = number of rising edges so far; "cycle t" is the time after edge t.
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    bit run = 1'b0;

    // Expectations keyed by cycle*2 + instance.
    int e_addr[int];
    int e_data[int];
    bit e_done[int];
    bit e_busy[int];
    bit e_rst[int];
    int rf[2];                 // first cycle each instance is expected ready
    int log0[$], log1[$];      // observed write addresses
    int dlog0[$], dlog1[$];    // cycles where done was seen

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                int key, a, d;
                bit en, dn, bs, rdy;
                key = cyc * 2 + i;
                if (i == 0) begin
                    en = bus.wr_en;  a = int'(bus.wr_addr);  d = int'(bus.wr_data);
                    dn = bus.done;   bs = bus.busy;          rdy = bus.cmd_ready;
                end else begin
                    en = sbus.wr_en; a = int'(sbus.wr_addr); d = int'(sbus.wr_data);
                    dn = sbus.done;  bs = sbus.busy;         rdy = sbus.cmd_ready;
                end
                if (e_rst.exists(cyc)) begin
                    chk("rst_wr_en", int'(en), 0);
                    chk("rst_wr_addr", a, 0);
                    chk("rst_wr_data", d, 0);
                    chk("rst_done", int'(dn), 0);
                    chk("rst_busy", int'(bs), 0);
                    chk("rst_cmd_ready", int'(rdy), 0);
                end else begin
                    chk("wr_en", int'(en), int'(e_addr.exists(key)));
                    if (en && e_addr.exists(key)) begin
                        chk("wr_addr", a, e_addr[key]);
                        chk("wr_data", d, e_data[key]);
                    end
                    chk("done", int'(dn), int'(e_done.exists(key)));
                    chk("busy", int'(bs), int'(e_busy.exists(key)));
                    chk("cmd_ready", int'(rdy), int'(!e_busy.exists(key)));
                end
                if (i == 0) begin
                    if (en) log0.push_back(a);
                    if (dn) dlog0.push_back(cyc);
                end else begin
                    if (en) log1.push_back(a);
                    if (dn) dlog1.push_back(cyc);
                end
            end
        end
    end

    // Model: clip with plain min/compare, enumerate pixels row-major.
    function automatic void sched(input int i, input int n, input int op,
                                  input int x, input int y, input int w,
                                  input int h, input int col);
        int hr, vr, wc, hc, p;
        hr = (i == 0) ? 640 : 32;
        vr = (i == 0) ? 480 : 24;
        if (op == 1) begin x = 0; y = 0; w = hr; h = vr; end
        wc = (x >= hr || w == 0) ? 0 : ((w < hr - x) ? w : hr - x);
        hc = (y >= vr || h == 0) ? 0 : ((h < vr - y) ? h : vr - y);
        p  = wc * hc;
        for (int k = 0; k < p; k++) begin
            e_addr[(n + 1 + k) * 2 + i] = (y + k / wc) * hr + x + k % wc;
            e_data[(n + 1 + k) * 2 + i] = col;
        end
        e_done[(n + p + 1) * 2 + i] = 1'b1;
        for (int t = n; t <= n + p + 1; t++) e_busy[t * 2 + i] = 1'b1;
        rf[i] = n + p + 2;
    endfunction

    task automatic wait_t(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    task automatic drive(input int i, input bit v, input int op, input int x,
                         input int y, input int w, input int h, input int col);
        if (i == 0) begin
            bus.cmd_valid = v; bus.cmd_op = op[0];
            bus.cmd_x = x[9:0]; bus.cmd_y = y[9:0]; bus.cmd_w = w[9:0]; bus.cmd_h = h[9:0];
            bus.cmd_colour = col[7:0];
        end else begin
            sbus.cmd_valid = v; sbus.cmd_op = op[0];
            sbus.cmd_x = x[9:0]; sbus.cmd_y = y[9:0]; sbus.cmd_w = w[9:0]; sbus.cmd_h = h[9:0];
            sbus.cmd_colour = col[7:0];
        end
    endtask

    // Present a command, predict its accept edge, return at that edge.
    task automatic send(input int i, input int op, input int x, input int y,
                        input int w, input int h, input int col, output int n);
        int c;
        c = cyc;
        drive(i, 1'b1, op, x, y, w, h, col);
        n = ((c > rf[i]) ? c : rf[i]) + 1;
        sched(i, n, op, x, y, w, h, col);
        wait_t(n);
    endtask

    // Drop valid and scramble the inputs; latched values must not care.
    task automatic release_cmd(input int i);
        drive(i, 1'b0, 0, 1023, 1023, 1023, 1023, 8'hEE);
    endtask

    task automatic pulse_reset(input int k);
        int c, lim;
        int kill[$];
        c = cyc;
        lim = (c + 1) * 2;
        reset_n = 1'b0;
        foreach (e_addr[kk]) if (kk >= lim) kill.push_back(kk);
        foreach (kill[j]) begin e_addr.delete(kill[j]); e_data.delete(kill[j]); end
        kill.delete();
        foreach (e_done[kk]) if (kk >= lim) kill.push_back(kk);
        foreach (kill[j]) e_done.delete(kill[j]);
        kill.delete();
        foreach (e_busy[kk]) if (kk >= lim) kill.push_back(kk);
        foreach (kill[j]) e_busy.delete(kill[j]);
        for (int t = c + 1; t <= c + k; t++) e_rst[t] = 1'b1;
        rf[0] = c + k + 1;
        rf[1] = c + k + 1;
        wait_t(c + k);
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, bad;
        drive(0, 1'b0, 0, 0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 3; t++) e_rst[t] = 1'b1;
        rf[0] = 4;
        rf[1] = 4;
        run = 1'b1;
        wait_t(3);
        reset_n = 1'b1;
        wait_t(5);

        // Basic 3x2 rectangle.
        log0.delete(); dlog0.delete();
        send(0, 0, 10, 20, 3, 2, 8'h5A, n);
        release_cmd(0);
        wait_t(rf[0] + 1);
        chk("t1_count", log0.size(), 6);
        if (log0.size() == 6) begin
            chk("t1_a0", log0[0], 12810); chk("t1_a2", log0[2], 12812);
            chk("t1_a3", log0[3], 13450); chk("t1_a5", log0[5], 13452);
        end
        chk("t1_done_n", dlog0.size(), 1);
        if (dlog0.size() == 1) chk("t1_done_lat", dlog0[0] - n, 7);

        // Bottom-right corner clip.
        log0.delete(); dlog0.delete();
        send(0, 0, 638, 479, 5, 5, 8'hA5, n);
        release_cmd(0);
        wait_t(rf[0] + 1);
        chk("t2_count", log0.size(), 2);
        if (log0.size() == 2) begin
            chk("t2_a0", log0[0], 307198); chk("t2_a1", log0[1], 307199);
        end
        if (dlog0.size() == 1) chk("t2_done_lat", dlog0[0] - n, 3);
        else chk("t2_done_n", dlog0.size(), 1);

        // Fully clipped: x off-screen, then zero width.
        log0.delete(); dlog0.delete();
        send(0, 0, 640, 0, 4, 4, 8'h33, n);
        release_cmd(0);
        wait_t(rf[0] + 1);
        chk("t3_count", log0.size(), 0);
        if (dlog0.size() == 1) chk("t3_done_lat", dlog0[0] - n, 1);
        else chk("t3_done_n", dlog0.size(), 1);
        chk("t3_ready_from", rf[0] - n, 2);
        log0.delete(); dlog0.delete();
        send(0, 0, 5, 5, 0, 3, 8'h44, n);
        release_cmd(0);
        wait_t(rf[0] + 1);
        chk("t4_count", log0.size(), 0);
        if (dlog0.size() == 1) chk("t4_done_lat", dlog0[0] - n, 1);
        else chk("t4_done_n", dlog0.size(), 1);

        // Reset during the 5th write of a 4x4, then a 1x1 at the origin.
        log0.delete(); dlog0.delete();
        send(0, 0, 0, 0, 4, 4, 8'h77, n);
        release_cmd(0);
        wait_t(n + 5);
        pulse_reset(1);
        wait_t(cyc + 4);
        chk("t5_count", log0.size(), 5);
        if (log0.size() == 5) chk("t5_last", log0[4], 640);
        chk("t5_no_done", dlog0.size(), 0);
        log0.delete();
        send(0, 0, 0, 0, 1, 1, 8'h99, n);
        release_cmd(0);
        wait_t(rf[0] + 1);
        chk("t5b_count", log0.size(), 1);
        if (log0.size() == 1) chk("t5b_a0", log0[0], 0);

        // Two back-to-back 2x1 rectangles with valid held high.
        log0.delete(); dlog0.delete();
        send(0, 0, 100, 200, 2, 1, 8'h11, n);
        send(0, 0, 300, 400, 2, 1, 8'h22, n2);
        release_cmd(0);
        wait_t(rf[0] + 1);
        chk("t6_gap", n2 - n, 5);
        chk("t6_count", log0.size(), 4);
        if (log0.size() == 4) begin
            chk("t6_a0", log0[0], 128100); chk("t6_a1", log0[1], 128101);
            chk("t6_a2", log0[2], 256300); chk("t6_a3", log0[3], 256301);
        end
        if (dlog0.size() == 2) chk("t6_done_gap", dlog0[1] - dlog0[0], 5);
        else chk("t6_done_n", dlog0.size(), 2);

        // Full clears on the small screen, colour 0x00 then 0xC3, queued.
        log1.delete(); dlog1.delete();
        send(1, 1, 7, 9, 3, 3, 8'h00, n);
        send(1, 1, 1, 2, 1, 1, 8'hC3, n2);
        release_cmd(1);
        wait_t(rf[1] + 1);
        chk("t7_count", log1.size(), 1536);
        bad = 0;
        foreach (log1[j]) if (log1[j] != j % 768) bad++;
        chk("t7_contig", bad, 0);
        chk("t7_done_n", dlog1.size(), 2);
        chk("t7_gap", n2 - n, 771);

        wait_t(cyc + 3);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
